// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result serial transmitter.
// Latency: none (types and constants only).
// Backpressure: n/a.
// Contents: opcode enum, frame/field widths, transmitter state enum.
package alu_pkg;

  localparam int FRAME_BITS = 11;  // start + 8 data + parity + stop
  localparam int RESULT_W   = 6;
  localparam int OP_W       = 2;
  localparam int DATA_W     = RESULT_W + OP_W;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

endpackage

// File: rtl/alu_bit_tick.sv
// Bit-period timer: marks the last clock cycle of each serial bit.
// Latency: tick is combinational from the registered count; first tick CLKS_PER_BIT cycles after run rises.
// Backpressure: none; count is held at zero whenever run is low.
// Ports: clk, rst (async, active-high), run (count enable), tick (last cycle of bit period).
module alu_bit_tick #(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // With CLKS_PER_BIT=1 LAST is 0, so tick fires every running cycle.
  assign tick = run && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!run || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_result_tx.sv
// Serialises one {op, result} byte as start, 8 data bits LSB first, even parity, stop.
// Latency: tx falls the cycle after the handshake; frame lasts 11*CLKS_PER_BIT cycles, frame_done one cycle later.
// Backpressure: in_ready is high only in IDLE, so at most one frame per 11*CLKS_PER_BIT+1 cycles.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_result/in_op input handshake;
//        tx serial line (idle high); busy (frame in progress); frame_done (one-cycle pulse after stop bit).
module alu_result_tx
  import alu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [RESULT_W-1:0] in_result,
  input  logic [OP_W-1:0]     in_op,
  output logic                tx,
  output logic                busy,
  output logic                frame_done
);

  // Index of the final data bit (start, parity and stop are the other three).
  localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 4);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              frame_done_q, frame_done_d;
  logic              tick;
  logic              xfer;

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign tx         = tx_q;
  assign frame_done = frame_done_q;
  assign xfer       = in_valid && in_ready;

  alu_bit_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_bit_tick (
    .clk (clk),
    .rst (rst),
    .run (busy),
    .tick(tick)
  );

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    parity_d     = parity_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d   = START;
          shift_d   = {in_op, in_result};
          parity_d  = ^{in_op, in_result};
          bit_idx_d = '0;
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_d   = {1'b0, shift_q[DATA_W-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) state_d = PARITY;
        end
      end
      PARITY: begin
        if (tick) state_d = STOP;
      end
      STOP: begin
        if (tick) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The line level is decided from the next state so the tx flop already
    // holds the correct bit in the first cycle of every new bit period.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      parity_q     <= 1'b0;
      tx_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      parity_q     <= parity_d;
      tx_q         <= tx_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
